obi_slave_arbiter: RTL and testbench
====================================

OBI_SLAVE_ARBITER -- requirements
Module: obi_slave_arbiter

Interface
REQ-001 SHALL have parameter NMASTER, default 2: number of requesting OBI masters, valid range 2..16.
REQ-002 SHALL have parameter MAX_OUTSTANDING, default 2: maximum granted-but-unanswered transactions, valid range 1..8.
REQ-003 SHALL have port clk_i, input, 1 bit: clock, all state updates on the rising edge.
REQ-004 SHALL have port rst_ni, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port master_req_i, input, obi_req_t[NMASTER]: per-master request (req, we, be, addr, wdata).
REQ-006 SHALL have port master_resp_o, output, obi_resp_t[NMASTER]: per-master response (gnt, rvalid, rdata).
REQ-007 SHALL have port slave_req_o, output, obi_req_t: request to the shared slave.
REQ-008 SHALL have port slave_resp_i, input, obi_resp_t: response from the shared slave.

Function
REQ-009 SHALL select one winner among masters with master_req_i[i].req=1 whenever no lock is active (arbitration policy per REQ-024/025).
REQ-010 SHALL drive slave_req_o to the winner's request fields, with req=1 only when a winner exists and the outstanding count < MAX_OUTSTANDING; otherwise slave_req_o='0.
REQ-011 SHALL drive master_resp_o[winner].gnt = slave_resp_i.gnt only while slave_req_o.req=1; all other gnt outputs SHALL be 0.
REQ-012 SHALL set a lock on the winner when slave_req_o.req=1 and slave_resp_i.gnt=0, holding that selection until the cycle its gnt is seen, so the presented request never switches mid-handshake.
REQ-013 SHALL push the winner index into an index FIFO of depth MAX_OUTSTANDING on each handshake (slave_req_o.req & slave_resp_i.gnt), combinationally in the grant cycle, zero added latency.
REQ-014 SHALL, on slave_resp_i.rvalid=1 with count>0, assert master_resp_o[head].rvalid and forward rdata to that master only, in the same cycle, and pop the FIFO.
REQ-015 SHALL keep rdata of non-addressed masters at 0 and rvalid of all masters at 0 when slave_resp_i.rvalid=0.
REQ-016 SHALL ignore slave_resp_i.rvalid when count=0 (no master sees it, no state change).
REQ-017 SHALL leave count unchanged on simultaneous push and pop, including at count=MAX_OUTSTANDING-1 and at count=MAX_OUTSTANDING; a pop at count=MAX_OUTSTANDING SHALL NOT enable a grant in the same cycle.
REQ-018 SHALL wrap FIFO read/write pointers modulo MAX_OUTSTANDING.
REQ-019 SHALL return responses strictly in grant order regardless of which masters issued them.
REQ-020 SHALL allow the slave's rvalid in the same cycle as or any cycle after gnt; no timeout.

Reset
REQ-021 SHALL on rst_ni=0 clear count, FIFO pointers, lock and round-robin pointer to 0, asynchronously.
REQ-022 SHALL during reset drive slave_req_o='0 and master_resp_o='0.
REQ-023 SHALL discard all outstanding transactions on reset mid-operation; rvalid arriving after reset release with count=0 is ignored per REQ-016.

Configuration
REQ-024 SHALL, with macro OBI_ARB_FIXED_PRIO_EN defined, use fixed priority: lowest requesting index wins; the round-robin pointer is not implemented.
REQ-025 SHALL, without OBI_ARB_FIXED_PRIO_EN, use round-robin: search starts at pointer p, and after a handshake by master w, p becomes (w+1) mod NMASTER.

Verification
REQ-026 SHALL cover: NMASTER=2, both masters req continuously, slave gnt=1 every cycle, rvalid next cycle -> grants alternate 0,1,0,1 (default build); with OBI_ARB_FIXED_PRIO_EN master 0 granted every cycle.
REQ-027 SHALL cover: MAX_OUTSTANDING=2, slave gnt=1, rvalid withheld -> two grants then slave_req_o.req=0; rvalid in cycle 5 -> head master gets rvalid, grant resumes cycle 6.
REQ-028 SHALL cover: master 1 req addr 0x1000_0040, slave gnt=0 for 3 cycles while master 0 raises req -> slave_req_o keeps addr 0x1000_0040 until gnt, master 0 granted next.
REQ-029 SHALL cover: grants to masters 1,0,1 with rdata 0xA,0xB,0xC returned in order -> master 1 gets 0xA, master 0 0xB, master 1 0xC, no rvalid to others.
REQ-030 SHALL cover: rst_ni pulsed low with 2 outstanding, then slave rvalid=1 -> no master_resp_o rvalid, count stays 0, next request granted normally.

Source files
------------

// File: rtl/obi_slave_arbiter.sv
// +--------------------------------------------------------------------------+
// | obi_slave_arbiter : N-master to 1-slave OBI arbiter with in-order         |
// |                     response routing. Macro OBI_ARB_FIXED_PRIO_EN         |
// |                     selects fixed priority instead of round-robin.        |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
`default_nettype none

package obi_arb_pkg;
  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;
endpackage

module obi_slave_arbiter
  import obi_arb_pkg::*;
#(
  parameter int NMASTER         = 2,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  obi_req_t  master_req_i  [NMASTER],
  output obi_resp_t master_resp_o [NMASTER],
  output obi_req_t  slave_req_o,
  input  obi_resp_t slave_resp_i
);

  localparam int IW = $clog2(NMASTER);
  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] C_MAX_CNT  = CW'(MAX_OUTSTANDING);
  localparam logic [PW-1:0] C_LAST_PTR = PW'(MAX_OUTSTANDING - 1);

  logic [CW-1:0]      r_count;
  logic [PW-1:0]      r_wptr;
  logic [PW-1:0]      r_rptr;
  logic [IW-1:0]      r_fifo [2**PW];
  logic               r_lock;
  logic [IW-1:0]      r_lock_idx;

  logic [NMASTER-1:0] w_reqs;
  logic [IW-1:0]      w_sel;
  logic [IW-1:0]      w_winner;
  logic [IW-1:0]      w_head;
  logic               w_has_winner;
  logic               w_issue;
  logic               w_push;
  logic               w_pop;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == C_LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  for (genvar i = 0; i < NMASTER; i++) begin : g_req
    assign w_reqs[i] = master_req_i[i].req;
  end

`ifdef OBI_ARB_FIXED_PRIO_EN
  always_comb begin
    w_sel = '0;
    for (int i = NMASTER - 1; i >= 0; i--) begin
      if (w_reqs[i]) w_sel = IW'(i);
    end
  end
`else
  localparam logic [IW-1:0] C_LAST_IDX = IW'(NMASTER - 1);
  logic [IW-1:0] r_rr_ptr;
  logic [IW:0]   w_cand;

  // Walk from the farthest candidate back to the pointer so the nearest wins.
  always_comb begin
    w_sel  = '0;
    w_cand = '0;
    for (int k = NMASTER - 1; k >= 0; k--) begin
      w_cand = {1'b0, r_rr_ptr} + (IW+1)'(k);
      if (w_cand >= (IW+1)'(NMASTER)) w_cand = w_cand - (IW+1)'(NMASTER);
      if (w_reqs[w_cand[IW-1:0]]) w_sel = w_cand[IW-1:0];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rr_ptr <= '0;
    end else if (w_push) begin
      r_rr_ptr <= (w_winner == C_LAST_IDX) ? '0 : w_winner + IW'(1);
    end
  end
`endif

  assign w_winner     = r_lock ? r_lock_idx : w_sel;
  assign w_has_winner = r_lock ? w_reqs[r_lock_idx] : |w_reqs;
  assign w_issue      = rst_ni && w_has_winner && (r_count < C_MAX_CNT);
  assign w_push       = w_issue && slave_resp_i.gnt;
  assign w_pop        = rst_ni && slave_resp_i.rvalid && (r_count != '0);
  assign w_head       = r_fifo[r_rptr];

  always_comb begin
    slave_req_o = '0;
    if (w_issue) begin
      slave_req_o     = master_req_i[w_winner];
      slave_req_o.req = 1'b1;
    end
  end

  always_comb begin
    for (int i = 0; i < NMASTER; i++) begin
      master_resp_o[i] = '0;
      if (w_issue && (w_winner == IW'(i))) master_resp_o[i].gnt = slave_resp_i.gnt;
      if (w_pop && (w_head == IW'(i))) begin
        master_resp_o[i].rvalid = 1'b1;
        master_resp_o[i].rdata  = slave_resp_i.rdata;
      end
    end
  end

  // A pop at full does not free a slot for this cycle: w_issue uses r_count.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_count    <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_lock     <= 1'b0;
      r_lock_idx <= '0;
      for (int i = 0; i < 2**PW; i++) r_fifo[i] <= '0;
    end else begin
      if (w_push) begin
        r_fifo[r_wptr] <= w_winner;
        r_wptr         <= ptr_next(r_wptr);
      end
      if (w_pop) r_rptr <= ptr_next(r_rptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_issue && !slave_resp_i.gnt) begin
        r_lock     <= 1'b1;
        r_lock_idx <= w_winner;
      end else if (w_push) begin
        r_lock     <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_obi_slave_arbiter.sv
// Bench for obi_slave_arbiter: directed scenarios plus random traffic against
// a queue-based transaction model.
`default_nettype none

module tb_obi_slave_arbiter;
  import obi_arb_pkg::*;

  localparam int NM = 2;
  localparam int MO = 2;

  logic      clk = 1'b0;
  logic      rst_ni;
  obi_req_t  mreq  [NM];
  obi_resp_t mresp [NM];
  obi_req_t  sreq;
  obi_resp_t sresp;

  int checks = 0;
  int errors = 0;

  // Model state: outstanding grant order, arbitration pointer, pending lock.
  int m_q[$];
  int m_rr     = 0;
  bit m_locked = 0;
  int m_lidx   = 0;

  // Sampled DUT observations from the most recent cycle.
  int          s_gnt_idx;
  int          s_rv_idx;
  logic [31:0] s_rdata;
  logic        s_req;
  logic [31:0] s_addr;

  always #5 clk = ~clk;

  obi_slave_arbiter #(.NMASTER(NM), .MAX_OUTSTANDING(MO)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .master_req_i (mreq),
    .master_resp_o(mresp),
    .slave_req_o  (sreq),
    .slave_resp_i (sresp)
  );

  task automatic check_val(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int arb_start();
`ifdef OBI_ARB_FIXED_PRIO_EN
    return 0;
`else
    return m_rr;
`endif
  endfunction

  // One clock: inputs already driven at negedge; check, then advance model.
  task automatic cycle();
    int        win;
    bit        have, issue, hs, pop;
    obi_req_t  es;
    obi_resp_t er [NM];
    #1;
    win  = 0;
    have = 0;
    if (m_locked) begin
      win  = m_lidx;
      have = mreq[win].req;
    end else begin
      for (int k = 0; k < NM; k++) begin
        int c;
        c = (arb_start() + k) % NM;
        if (!have && mreq[c].req) begin
          have = 1;
          win  = c;
        end
      end
    end
    issue = (rst_ni === 1'b1) && have && (m_q.size() < MO);
    hs    = issue && sresp.gnt;
    pop   = (rst_ni === 1'b1) && sresp.rvalid && (m_q.size() > 0);
    es = '0;
    if (issue) begin
      es     = mreq[win];
      es.req = 1'b1;
    end
    for (int i = 0; i < NM; i++) er[i] = '0;
    if (issue) er[win].gnt = sresp.gnt;
    if (pop) begin
      er[m_q[0]].rvalid = 1'b1;
      er[m_q[0]].rdata  = sresp.rdata;
    end
    check_val("slave_req", 72'(sreq), 72'(es));
    for (int i = 0; i < NM; i++) check_val($sformatf("master_resp[%0d]", i), 72'(mresp[i]), 72'(er[i]));
    s_gnt_idx = -1;
    s_rv_idx  = -1;
    s_rdata   = '0;
    for (int i = NM - 1; i >= 0; i--) begin
      if (mresp[i].gnt) s_gnt_idx = i;
      if (mresp[i].rvalid) begin
        s_rv_idx = i;
        s_rdata  = mresp[i].rdata;
      end
    end
    s_req  = sreq.req;
    s_addr = sreq.addr;
    @(posedge clk);
    if (rst_ni !== 1'b1) begin
      m_q.delete();
      m_rr     = 0;
      m_locked = 0;
      m_lidx   = 0;
    end else begin
      if (pop) void'(m_q.pop_front());
      if (hs) begin
        m_q.push_back(win);
        m_rr = (win + 1) % NM;
      end
      if (issue && !sresp.gnt) begin
        m_locked = 1;
        m_lidx   = win;
      end else if (hs) begin
        m_locked = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic clr_in();
    for (int i = 0; i < NM; i++) mreq[i] = '0;
    sresp = '0;
  endtask

  task automatic drain();
    clr_in();
    sresp.rvalid = 1'b1;
    repeat (MO + 1) cycle();
    sresp.rvalid = 1'b0;
  endtask

  initial begin
    int first;
    rst_ni = 1'b0;
    clr_in();
    mreq[0].req  = 1'b1;
    mreq[0].addr = 32'h1234_5678;
    sresp.gnt    = 1'b1;
    sresp.rvalid = 1'b1;
    @(negedge clk);
    repeat (2) cycle();
    check_int("reset_no_req", int'(s_req), 0);

    // Both masters requesting, slave grants every cycle, rvalid one cycle later.
    rst_ni = 1'b1;
    clr_in();
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < NM; i++) begin
        mreq[i].req  = 1'b1;
        mreq[i].addr = 32'h100 * (i + 1);
      end
      sresp.gnt    = 1'b1;
      sresp.rvalid = (k > 0);
      sresp.rdata  = 32'hD000_0000 + k;
      cycle();
`ifdef OBI_ARB_FIXED_PRIO_EN
      check_int($sformatf("stream_gnt_%0d", k), s_gnt_idx, 0);
`else
      check_int($sformatf("stream_gnt_%0d", k), s_gnt_idx, k % 2);
`endif
    end
    drain();

    // Outstanding limit: two grants, stall, rvalid at full, resume after.
    for (int k = 1; k <= 6; k++) begin
      clr_in();
      mreq[0].req = (k != 5);
      mreq[1].req = (k != 5);
      sresp.gnt   = 1'b1;
      sresp.rvalid = (k == 5);
      sresp.rdata  = 32'h0000_00E5;
      cycle();
      if (k == 1) first = s_gnt_idx;
      if (k == 3 || k == 4 || k == 5) check_int($sformatf("limit_req_c%0d", k), int'(s_req), 0);
      if (k == 5) check_int("limit_rv_head", s_rv_idx, first);
      if (k == 6) check_int("limit_resume", int'(s_req), 1);
    end
    drain();

    // Lock: master 1 waits for gnt while master 0 joins.
    for (int k = 1; k <= 5; k++) begin
      clr_in();
      mreq[1].req  = (k <= 4);
      mreq[1].addr = 32'h1000_0040;
      mreq[0].req  = (k >= 2);
      mreq[0].addr = 32'h2000_0000;
      sresp.gnt    = (k >= 4);
      cycle();
      if (k <= 4) check_val($sformatf("lock_addr_c%0d", k), 72'(s_addr), 72'(32'h1000_0040));
      if (k == 4) check_int("lock_gnt_m1", s_gnt_idx, 1);
      if (k == 5) check_int("lock_then_m0", s_gnt_idx, 0);
    end
    drain();

    // In-order return: grants 1,0,1 answered with A,B,C.
    for (int k = 1; k <= 5; k++) begin
      clr_in();
      mreq[1].req  = (k == 1 || k == 3 || k == 4);
      mreq[0].req  = (k == 2);
      sresp.gnt    = 1'b1;
      sresp.rvalid = (k >= 3);
      sresp.rdata  = 32'hA + (k - 3);
      cycle();
      case (k)
        1: check_int("order_gnt1", s_gnt_idx, 1);
        2: check_int("order_gnt2", s_gnt_idx, 0);
        3: begin
          check_int("order_rv_a", s_rv_idx, 1);
          check_val("order_rdata_a", 72'(s_rdata), 72'(32'hA));
          check_int("order_full_nogrant", s_gnt_idx, -1);
        end
        4: begin
          check_int("order_rv_b", s_rv_idx, 0);
          check_val("order_rdata_b", 72'(s_rdata), 72'(32'hB));
          check_int("order_gnt3", s_gnt_idx, 1);
        end
        default: begin
          check_int("order_rv_c", s_rv_idx, 1);
          check_val("order_rdata_c", 72'(s_rdata), 72'(32'hC));
        end
      endcase
    end
    drain();

    // Reset with two outstanding, then a stray rvalid.
    for (int k = 1; k <= 5; k++) begin
      clr_in();
      rst_ni       = (k != 3);
      mreq[0].req  = (k == 1 || k == 5);
      mreq[1].req  = (k == 2);
      sresp.gnt    = 1'b1;
      sresp.rvalid = (k == 4);
      sresp.rdata  = 32'h55;
      cycle();
      if (k == 3) check_int("midreset_req", int'(s_req), 0);
      if (k == 4) check_int("post_reset_rv", s_rv_idx, -1);
      if (k == 5) check_int("post_reset_gnt", s_gnt_idx, 0);
    end
    drain();

    // Random traffic with occasional resets.
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < NM; i++) begin
        mreq[i].req   = 1'($urandom_range(0, 1));
        mreq[i].we    = 1'($urandom_range(0, 1));
        mreq[i].be    = 4'($urandom);
        mreq[i].addr  = $urandom;
        mreq[i].wdata = $urandom;
      end
      sresp.gnt    = ($urandom_range(0, 3) != 0);
      sresp.rvalid = 1'($urandom_range(0, 1));
      sresp.rdata  = $urandom;
      rst_ni       = ($urandom_range(0, 99) != 0);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
